// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the ROM word address and
// registers the combinational ROM read-back into an IF/ID valid/ready stage.
//
// state  | meaning
// BOOT   | first cycle after reset, no fetch; redirect may still load the PC
// RUN    | normal fetch, one instruction per cycle while decode accepts
// HALTED | terminal until reset; no fetch, redirect ignored, IF/ID drains

module fetch_unit #(
   parameter int          DATA_WIDTH = 32,
   parameter int          BUS_WIDTH  = 10,
   parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  halt,
   input  logic                  redirect,
   input  logic [31:0]           redirect_pc,
   output logic [BUS_WIDTH-1:0]  imem_addr,
   input  logic [DATA_WIDTH-1:0] imem_rdata,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_instr,
   output logic [31:0]           out_pc,
   output logic [31:0]           out_pc_plus4,
   output logic                  fault,
   output logic                  halted
);

   typedef enum logic [1:0] {
      BOOT   = 2'd0,
      RUN    = 2'd1,
      HALTED = 2'd2
   } state_t;

   state_t      state;
   state_t      state_next;
   logic [31:0] pc;
   logic [31:0] pc_next;
   logic [31:0] pc_inc;
   logic        fire;
   logic        take_redirect;
   logic        valid_next;
   logic        fault_next;

   // ROM only sees the word index; upper PC bits alias past the ROM end.
   assign imem_addr = pc[BUS_WIDTH+1:2];
   assign pc_inc    = pc + 32'd4;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= BOOT;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next    = state;
      fire          = 1'b0;
      take_redirect = 1'b0;
      case (state)
         BOOT: begin
            take_redirect = redirect & ~halt;
            state_next    = halt ? HALTED : RUN;
         end
         RUN: begin
            take_redirect = redirect & ~halt;
            fire          = ~halt & ~redirect & (~out_valid | out_ready);
            state_next    = halt ? HALTED : RUN;
         end
         HALTED: begin
            state_next = HALTED;
         end
         default: begin
            state_next = BOOT;
         end
      endcase
   end

   // Redirect flushes the IF/ID stage even if decode is accepting it this cycle.
   always_comb begin
      pc_next    = pc;
      valid_next = out_valid;
      fault_next = fault;
      if (take_redirect) begin
         pc_next    = {redirect_pc[31:2], 2'b00};
         valid_next = 1'b0;
         fault_next = fault | (redirect_pc[1:0] != 2'b00);
      end else if (fire) begin
         pc_next    = pc_inc;
         valid_next = 1'b1;
      end else if (out_valid && out_ready) begin
         valid_next = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc        <= RESET_PC;
         out_valid <= 1'b0;
         fault     <= 1'b0;
         halted    <= 1'b0;
      end else begin
         pc        <= pc_next;
         out_valid <= valid_next;
         fault     <= fault_next;
         halted    <= (state_next == HALTED);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_instr    <= '0;
         out_pc       <= 32'd0;
         out_pc_plus4 <= 32'd0;
      end else if (fire) begin
         out_instr    <= imem_rdata;
         out_pc       <= pc;
         out_pc_plus4 <= pc_inc;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: behavioural ROM, hand-computed expectations
// checked with immediate assertions after each rising edge.

module tb_fetch_unit;

   logic        clk;
   logic        rst_n;
   logic        halt;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic [9:0]  imem_addr;
   logic [31:0] imem_rdata;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic [31:0] out_pc_plus4;
   logic        fault;
   logic        halted;

   int checks;
   int errors;

   logic [31:0] rom [0:1023];

   fetch_unit #(
      .DATA_WIDTH(32),
      .BUS_WIDTH (10),
      .RESET_PC  (32'h0000_0000)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .halt        (halt),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .imem_addr   (imem_addr),
      .imem_rdata  (imem_rdata),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_instr   (out_instr),
      .out_pc      (out_pc),
      .out_pc_plus4(out_pc_plus4),
      .fault       (fault),
      .halted      (halted)
   );

   assign imem_rdata = rom[imem_addr];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string tag, input logic [31:0] instr,
                          input logic [31:0] pc, input logic [31:0] pc4);
      chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
      chk({tag, "_instr"}, out_instr, instr);
      chk({tag, "_pc"}, out_pc, pc);
      chk({tag, "_pc4"}, out_pc_plus4, pc4);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      for (int i = 0; i < 1024; i++) rom[i] = 32'hA000_0000 + i;
      rom[0] = 32'h11;
      rom[1] = 32'h22;
      rom[2] = 32'h33;
      rom[3] = 32'h44;

      rst_n       = 1'b0;
      halt        = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 32'd0;
      out_ready   = 1'b1;
      #2;
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_instr", out_instr, 32'd0);
      chk("rst_pc", out_pc, 32'd0);
      chk("rst_pc4", out_pc_plus4, 32'd0);
      chk("rst_fault", {31'd0, fault}, 32'd0);
      chk("rst_halted", {31'd0, halted}, 32'd0);
      chk("rst_addr", {22'd0, imem_addr}, 32'd0);

      step();
      step();
      rst_n = 1'b1;
      // BOOT cycle: no fetch
      step();
      chk("boot_valid", {31'd0, out_valid}, 32'd0);
      chk("boot_addr", {22'd0, imem_addr}, 32'd0);
      step();
      chk_out("f0", 32'h11, 32'h0, 32'h4);
      chk("f0_addr", {22'd0, imem_addr}, 32'd1);
      step();
      chk_out("f1", 32'h22, 32'h4, 32'h8);

      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk_out("bp", 32'h22, 32'h4, 32'h8);
         chk("bp_addr", {22'd0, imem_addr}, 32'd2);
      end
      out_ready = 1'b1;
      step();
      chk_out("f2", 32'h33, 32'h8, 32'hC);
      step();
      chk_out("f3", 32'h44, 32'hC, 32'h10);

      redirect    = 1'b1;
      redirect_pc = 32'h40;
      step();
      chk("rd_valid", {31'd0, out_valid}, 32'd0);
      chk("rd_addr", {22'd0, imem_addr}, 32'd16);
      redirect = 1'b0;
      step();
      chk_out("rd_f", 32'hA000_0010, 32'h40, 32'h44);
      chk("rd_fault", {31'd0, fault}, 32'd0);

      redirect    = 1'b1;
      redirect_pc = 32'h42;
      step();
      chk("mis_valid", {31'd0, out_valid}, 32'd0);
      chk("mis_fault", {31'd0, fault}, 32'd1);
      chk("mis_addr", {22'd0, imem_addr}, 32'd16);
      redirect = 1'b0;
      step();
      chk_out("mis_f0", 32'hA000_0010, 32'h40, 32'h44);
      chk("mis_fault1", {31'd0, fault}, 32'd1);
      step();
      chk_out("mis_f1", 32'hA000_0011, 32'h44, 32'h48);
      chk("mis_fault2", {31'd0, fault}, 32'd1);

      halt        = 1'b1;
      redirect    = 1'b1;
      redirect_pc = 32'h80;
      step();
      chk("h_halted", {31'd0, halted}, 32'd1);
      chk("h_valid", {31'd0, out_valid}, 32'd0);
      chk("h_addr", {22'd0, imem_addr}, 32'd18);
      chk("h_fault", {31'd0, fault}, 32'd1);
      halt        = 1'b0;
      redirect_pc = 32'h100;
      for (int i = 0; i < 2; i++) begin
         step();
         chk("hs_halted", {31'd0, halted}, 32'd1);
         chk("hs_valid", {31'd0, out_valid}, 32'd0);
         chk("hs_addr", {22'd0, imem_addr}, 32'd18);
         chk("hs_pc", out_pc, 32'h44);
      end
      redirect = 1'b0;

      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_valid", {31'd0, out_valid}, 32'd0);
      chk("ar_fault", {31'd0, fault}, 32'd0);
      chk("ar_halted", {31'd0, halted}, 32'd0);
      chk("ar_addr", {22'd0, imem_addr}, 32'd0);
      step();
      rst_n = 1'b1;
      step();
      chk("ar_boot_valid", {31'd0, out_valid}, 32'd0);
      step();
      chk_out("ar_f0", 32'h11, 32'h0, 32'h4);

      redirect    = 1'b1;
      redirect_pc = 32'hFFFF_FFFC;
      step();
      chk("wr_valid", {31'd0, out_valid}, 32'd0);
      chk("wr_addr", {22'd0, imem_addr}, 32'h3FF);
      redirect = 1'b0;
      step();
      chk_out("wr_top", 32'hA000_03FF, 32'hFFFF_FFFC, 32'h0);
      chk("wr_addr0", {22'd0, imem_addr}, 32'd0);
      step();
      chk_out("wr_zero", 32'h11, 32'h0, 32'h4);
      chk("wr_fault", {31'd0, fault}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #20000;
      errors++;
      $display("FAIL timeout observed running expected finished");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the instruction ROM. It owns the program counter and drives the ROM word address.
- It captures the combinational instruction read-back into an IF/ID output register with a valid/ready handshake to the decode stage.
- It handles branch/jump redirects, pipeline flush, decode backpressure and a sticky halt.

Parameters:
- DATA_WIDTH, 32: instruction width; must match the ROM data width.
- BUS_WIDTH, 10: ROM word-address width; the ROM holds 2**BUS_WIDTH words.
- RESET_PC, 32'h0000_0000: byte address of the first fetch after reset; low two bits must be zero.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- halt  input  1  from decode (syscall halt); stop fetching permanently
- redirect  input  1  branch/jump taken; load new PC and flush
- redirect_pc  input  32  byte address of the redirect target
- imem_addr  output  BUS_WIDTH  ROM word address, driven to the ROM addr input
- imem_rdata  input  DATA_WIDTH  ROM instruction read-back; same-cycle combinational
- out_valid  output  1  IF/ID register holds a valid instruction
- out_ready  input  1  decode accepts the IF/ID register this cycle
- out_instr  output  DATA_WIDTH  fetched instruction
- out_pc  output  32  byte address of out_instr
- out_pc_plus4  output  32  out_pc + 4 (link/branch base)
- fault  output  1  sticky: misaligned redirect target seen
- halted  output  1  fetch unit is in HALTED

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n. Assertion immediately forces:
  - pc=RESET_PC, state=BOOT
  - out_valid=0, out_instr=0, out_pc=0, out_pc_plus4=0
  - fault=0, halted=0
- Reset mid-operation discards any in-flight instruction.
- imem_addr = pc[BUS_WIDTH+1:2], combinational, in every state.
- pc bits above BUS_WIDTH+1 are ignored by the ROM, so fetches past the ROM end alias from word 0. pc itself keeps full 32-bit value.
- State machine:
  - BOOT: one cycle, no fetch. Next state is HALTED if halt=1, else RUN.
  - RUN: normal fetch. Goes to HALTED when halt=1.
  - HALTED: terminal until reset. No fetch; redirect ignored; halted=1 (registered, asserted the cycle after entry).
- Fetch condition: fire = (state==RUN) & ~halt & ~redirect & (~out_valid | out_ready).
- On fire, at the clock edge:
  - out_instr<=imem_rdata, out_pc<=pc, out_pc_plus4<=pc+4, out_valid<=1
  - pc<=pc+4, modulo 2**32; 32'hFFFF_FFFC wraps to 0.
- Latency: the instruction at pc appears on out_* one cycle after the fire cycle. Sustained throughput is one instruction per cycle while out_ready=1.
- Backpressure: out_valid=1 & out_ready=0 means out_instr, out_pc, out_pc_plus4 and pc are all held stable, and no fetch occurs.
- Drain: out_valid & out_ready & ~fire clears out_valid. This covers HALTED, BOOT and the redirect cycle.
- Redirect (state RUN or BOOT, halt=0):
  - pc<={redirect_pc[31:2],2'b00}
  - out_valid<=0 (flush, regardless of out_ready)
  - No fetch that cycle. First fetch from the target fires the next cycle.
  - If redirect_pc[1:0]!=0, fault<=1 (sticky until reset); the fetch still proceeds from the aligned address.
- Simultaneous events:
  - halt & redirect same cycle: halt wins. Go to HALTED, pc unchanged, redirect ignored, fault not updated. out_valid drains normally via out_ready.
  - redirect while out_valid & out_ready: the handshake completes (decode consumes it); out_valid still goes 0.
- Outputs are registered except imem_addr. No combinational path from out_ready or redirect to imem_addr.

Test Plan:
- Reset release with RESET_PC=0, ROM words 0..3 = 11,22,33,44, out_ready=1 -> cycle 1 BOOT with out_valid=0. Then out_instr 11,22,33,44 on consecutive cycles with out_pc 0,4,8,C and out_pc_plus4 4,8,C,10.
- Backpressure: out_ready=0 for 3 cycles while out_pc=4 -> out_instr=22 and out_pc=4 held, imem_addr stays 2. Releasing out_ready gives out_pc=8 the next cycle, with no skip or duplicate.
- Redirect to 0x40 while out_valid=1 -> next cycle out_valid=0. The cycle after, out_pc=0x40 and out_instr=ROM[16]; fault=0.
- Redirect to 0x42 -> fetch proceeds from 0x40, fault=1 and stays 1 through further fetches until rst_n=0.
- Halt and redirect asserted together with out_valid=1, out_ready=1 -> halted=1 next cycle, out_valid=0, pc unchanged. No further fetch despite later redirects.
- Async reset pulse mid-run (between clock edges) -> out_valid, fault and halted fall immediately and imem_addr returns to RESET_PC>>2. Fetch resumes after one BOOT cycle.
